// File: rtl/otter_mem_pkg.sv
// Shared types for the memory port arbiter: FSM states, access sizes and
// the latched transaction record.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } mem_txn_t;

    // Instruction fetches are always full-word, unsigned reads.
    function automatic mem_txn_t fetch_txn(input logic [31:0] addr);
        mem_txn_t t;
        t.we    = 1'b0;
        t.addr  = addr;
        t.wdata = '0;
        t.size  = SIZE_WORD;
        t.sign  = 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts data grants issued while fetch is waiting; saturates at LIMIT and
// raises at_limit so the arbiter can hand the port to fetch.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign at_limit = (count == CW'(LIMIT));

    // Saturating counter; a fetch grant wins over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data accesses.
// One transaction in flight; data has priority unless fetch has been
// starved for STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
    import otter_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_GNT,
    output logic        IF_VALID,
    output logic [31:0] IF_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic        D_GNT,
    output logic        D_VALID,
    output logic [31:0] D_RDATA,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic        M_READY,
    input  logic [31:0] M_RDATA
);

    arb_state_t state;
    arb_state_t state_next;
    mem_txn_t   txn;
    logic       if_gnt;
    logic       d_gnt;
    logic       if_valid;
    logic       d_valid;
    logic       arbitrate;
    logic       at_limit;
    logic       busy;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (CLK),
        .rst_n    (RESET),
        .inc      (d_gnt && IF_REQ),
        .clr      (if_gnt),
        .at_limit (at_limit)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, completion strobes and the grant decision. Grants happen
    // in IDLE or in a completion cycle, giving back-to-back transactions.
    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_valid   = 1'b0;
        d_valid    = 1'b0;
        M_REQ      = 1'b0;
        arbitrate  = 1'b0;
        case (state)
            IDLE: begin
                arbitrate = 1'b1;
            end
            BUSY_I: begin
                M_REQ = 1'b1;
                if (M_READY) begin
                    if_valid   = 1'b1;
                    arbitrate  = 1'b1;
                    state_next = IDLE;
                end
            end
            BUSY_D: begin
                M_REQ = 1'b1;
                if (M_READY) begin
                    d_valid    = 1'b1;
                    arbitrate  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // While reset is asserted nothing is granted or completed.
        if (!RESET) begin
            arbitrate = 1'b0;
            if_valid  = 1'b0;
            d_valid   = 1'b0;
        end
        if (arbitrate) begin
            if (D_REQ && !(IF_REQ && at_limit)) begin
                d_gnt      = 1'b1;
                state_next = BUSY_D;
            end else if (IF_REQ) begin
                if_gnt     = 1'b1;
                state_next = BUSY_I;
            end
        end
    end

    // Capture the winner's attributes on the grant edge.
    always_ff @(posedge CLK) begin
        if (if_gnt) begin
            txn <= fetch_txn(IF_ADDR);
        end else if (d_gnt) begin
            txn <= '{we: D_WE, addr: D_ADDR, wdata: D_WDATA, size: D_SIZE, sign: D_SIGN};
        end
    end

    // Memory-side attributes are only presented while a transaction is
    // outstanding, so IDLE (and therefore post-reset) drives all zeros.
    assign busy     = (state != IDLE);
    assign M_WE     = busy & txn.we;
    assign M_ADDR   = busy ? txn.addr  : '0;
    assign M_WDATA  = busy ? txn.wdata : '0;
    assign M_SIZE   = busy ? txn.size  : '0;
    assign M_SIGN   = busy & txn.sign;

    assign IF_GNT   = if_gnt;
    assign D_GNT    = d_gnt;
    assign IF_VALID = if_valid;
    assign D_VALID  = d_valid;
    assign IF_RDATA = if_valid ? M_RDATA : '0;
    assign D_RDATA  = (d_valid && !txn.we) ? M_RDATA : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] WORD = 2'b10;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT, IF_VALID;
    logic [31:0] IF_RDATA;
    logic        D_REQ, D_WE, D_SIGN;
    logic [31:0] D_ADDR, D_WDATA;
    logic [1:0]  D_SIZE;
    logic        D_GNT, D_VALID;
    logic [31:0] D_RDATA;
    logic        M_REQ, M_WE, M_SIGN;
    logic [31:0] M_ADDR, M_WDATA;
    logic [1:0]  M_SIZE;
    logic        M_READY;
    logic [31:0] M_RDATA;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_SIZE(D_SIZE), .D_SIGN(D_SIGN),
        .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_SIZE(M_SIZE), .M_SIGN(M_SIGN),
        .M_READY(M_READY), .M_RDATA(M_RDATA)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 data), the
    // captured transaction, and how many data grants fetch has sat through.
    int          owner = 0;
    int          starve = 0;
    int          last_win = 0;
    logic        t_we, t_sign;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_size;

    logic        obs_if_gnt, obs_d_gnt, obs_if_valid, obs_d_valid, obs_m_req, obs_m_we;
    logic [31:0] obs_if_rdata, obs_d_rdata, obs_m_addr, obs_m_wdata;
    logic [1:0]  obs_m_size;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int   win;
        logic done, can, e_ifv, e_dv;
        @(negedge CLK);
        done = (owner != 0) && M_READY;
        can  = RESET && ((owner == 0) || done);
        win  = 0;
        if (can) begin
            if (D_REQ && (!IF_REQ || starve < LIMIT)) win = 2;
            else if (IF_REQ) win = 1;
        end
        e_ifv = RESET && owner == 1 && M_READY;
        e_dv  = RESET && owner == 2 && M_READY;

        obs_if_gnt = IF_GNT;   obs_d_gnt = D_GNT;
        obs_if_valid = IF_VALID; obs_d_valid = D_VALID;
        obs_if_rdata = IF_RDATA; obs_d_rdata = D_RDATA;
        obs_m_req = M_REQ; obs_m_we = M_WE; obs_m_addr = M_ADDR;
        obs_m_wdata = M_WDATA; obs_m_size = M_SIZE;

        chk("if_gnt",   32'(IF_GNT),   32'(win == 1));
        chk("d_gnt",    32'(D_GNT),    32'(win == 2));
        chk("if_valid", 32'(IF_VALID), 32'(e_ifv));
        chk("d_valid",  32'(D_VALID),  32'(e_dv));
        chk("if_rdata", IF_RDATA, e_ifv ? M_RDATA : 32'd0);
        chk("d_rdata",  D_RDATA, (e_dv && !t_we) ? M_RDATA : 32'd0);
        chk("m_req",    32'(M_REQ),  32'(owner != 0));
        chk("m_we",     32'(M_WE),   (owner != 0) ? 32'(t_we) : 32'd0);
        chk("m_addr",   M_ADDR,      (owner != 0) ? t_addr : 32'd0);
        chk("m_wdata",  M_WDATA,     (owner != 0) ? t_wdata : 32'd0);
        chk("m_size",   32'(M_SIZE), (owner != 0) ? 32'(t_size) : 32'd0);
        chk("m_sign",   32'(M_SIGN), (owner != 0) ? 32'(t_sign) : 32'd0);

        @(posedge CLK);
        last_win = win;
        if (!RESET) begin
            owner = 0;
            starve = 0;
        end else if (owner == 0 || done) begin
            owner = win;
            if (win == 1) begin
                t_we = 1'b0; t_addr = IF_ADDR; t_wdata = 32'd0; t_size = WORD; t_sign = 1'b0;
                starve = 0;
            end else if (win == 2) begin
                t_we = D_WE; t_addr = D_ADDR; t_wdata = D_WDATA; t_size = D_SIZE; t_sign = D_SIGN;
                if (IF_REQ && starve < LIMIT) starve++;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        IF_REQ = 0; IF_ADDR = 0; D_REQ = 0; D_WE = 0; D_ADDR = 0; D_WDATA = 0;
        D_SIZE = 0; D_SIGN = 0; M_READY = 0; M_RDATA = 0;
    endtask

    initial begin
        int d_run, d_run2, if_seen;
        RESET = 0;
        idle_inputs();
        @(posedge CLK); #1;

        // Reset holds everything quiet even with requests and M_READY up.
        IF_REQ = 1; D_REQ = 1; M_READY = 1;
        cycle();
        chk("rst_gnt", 32'({obs_if_gnt, obs_d_gnt}), 32'd0);
        idle_inputs();
        RESET = 1;
        cycle();
        chk("rst_m_req", 32'(obs_m_req), 32'd0);

        // Lone fetch: grant at 0, M_REQ 1..3, data at 3.
        IF_REQ = 1; IF_ADDR = 32'h100;
        cycle();
        chk("t23_gnt", 32'(obs_if_gnt), 32'd1);
        IF_REQ = 0;
        cycle();
        chk("t23_mreq1", 32'(obs_m_req), 32'd1);
        chk("t23_addr", obs_m_addr, 32'h100);
        cycle();
        chk("t23_mreq2", 32'(obs_m_req), 32'd1);
        M_READY = 1; M_RDATA = 32'h13;
        cycle();
        chk("t23_valid", 32'(obs_if_valid), 32'd1);
        chk("t23_rdata", obs_if_rdata, 32'h13);
        chk("t23_mreq3", 32'(obs_m_req), 32'd1);
        M_READY = 0;
        cycle();
        chk("t23_idle", 32'(obs_m_req), 32'd0);

        // Fetch and load together: data first, fetch granted on its completion.
        IF_REQ = 1; IF_ADDR = 32'h104; D_REQ = 1; D_ADDR = 32'h2000; D_WE = 0; D_SIZE = WORD;
        cycle();
        chk("t24_dgnt", 32'(obs_d_gnt), 32'd1);
        chk("t24_ifgnt0", 32'(obs_if_gnt), 32'd0);
        D_REQ = 0;
        cycle();
        M_READY = 1; M_RDATA = 32'hA5A5_0001;
        cycle();
        chk("t24_dvalid", 32'(obs_d_valid), 32'd1);
        chk("t24_drdata", obs_d_rdata, 32'hA5A5_0001);
        chk("t24_ifgnt", 32'(obs_if_gnt), 32'd1);
        IF_REQ = 0; M_RDATA = 32'h0000_0002;
        cycle();
        chk("t24_ifvalid", 32'(obs_if_valid), 32'd1);
        chk("t24_dvalid2", 32'(obs_d_valid), 32'd0);
        M_READY = 0;
        cycle();

        // Starvation: both held with instant completion.
        IF_REQ = 1; D_REQ = 1; M_READY = 1;
        d_run = 0; d_run2 = 0; if_seen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (obs_if_gnt) if_seen++;
            else if (obs_d_gnt && if_seen == 0) d_run++;
            else if (obs_d_gnt && if_seen == 1) d_run2++;
        end
        chk("t25_run1", 32'(d_run), 32'd4);
        chk("t25_run2", 32'(d_run2), 32'd4);
        chk("t25_ifs", 32'(if_seen), 32'd2);
        idle_inputs(); M_READY = 1;
        cycle();
        M_READY = 0;
        cycle();

        // Halfword store held stable until completion; no read data returned.
        D_REQ = 1; D_WE = 1; D_ADDR = 32'h3004; D_WDATA = 32'hDEADBEEF; D_SIZE = 2'b01;
        cycle();
        D_REQ = 0; D_WDATA = 32'h0; D_ADDR = 32'h0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("t26_we", 32'(obs_m_we), 32'd1);
            chk("t26_addr", obs_m_addr, 32'h3004);
            chk("t26_wdata", obs_m_wdata, 32'hDEADBEEF);
            chk("t26_size", 32'(obs_m_size), 32'd1);
        end
        M_READY = 1; M_RDATA = 32'h1234_5678;
        cycle();
        chk("t26_dvalid", 32'(obs_d_valid), 32'd1);
        chk("t26_drdata", obs_d_rdata, 32'd0);
        M_READY = 0;
        cycle();

        // Reset in the middle of a load abandons it.
        D_REQ = 1; D_WE = 0; D_ADDR = 32'h4000; D_SIZE = 2'b00; D_SIGN = 1;
        cycle();
        D_REQ = 0;
        cycle();
        RESET = 0;
        cycle();
        RESET = 1; M_READY = 1; M_RDATA = 32'hFFFF_FFFF;
        cycle();
        chk("t27_mreq", 32'(obs_m_req), 32'd0);
        chk("t27_dvalid", 32'(obs_d_valid), 32'd0);
        chk("t27_addr", obs_m_addr, 32'd0);
        M_READY = 0;
        cycle();

        // Fetch request withdrawn while data is busy never gets granted.
        D_REQ = 1; D_ADDR = 32'h5000;
        cycle();
        D_REQ = 0; IF_REQ = 1; IF_ADDR = 32'h200;
        cycle();
        IF_REQ = 0; M_READY = 1;
        cycle();
        chk("t28_dvalid", 32'(obs_d_valid), 32'd1);
        chk("t28_ifgnt", 32'(obs_if_gnt), 32'd0);
        M_READY = 0;
        cycle();
        chk("t28_idle", 32'(obs_m_req), 32'd0);

        // Random traffic with level-held requesters.
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            if (!IF_REQ || last_win == 1) begin
                IF_REQ = ($urandom % 100) < 50;
                IF_ADDR = $urandom;
            end else if (($urandom % 100) < 8) begin
                IF_REQ = 0;
            end
            if (!D_REQ || last_win == 2) begin
                D_REQ = ($urandom % 100) < 55;
                D_WE = $urandom % 2;
                D_ADDR = $urandom;
                D_WDATA = $urandom;
                D_SIZE = 2'($urandom % 3);
                D_SIGN = $urandom % 2;
            end else if (($urandom % 100) < 8) begin
                D_REQ = 0;
            end
            M_READY = ($urandom % 100) < 40;
            M_RDATA = $urandom;
            RESET = (($urandom % 100) < 2) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
